uart_tx_sched: RTL and testbench

- Two-requester scheduler that owns the UART transmitter's control inputs and shares it between requesters: CAN-to-UART bridge payload (port A) and local status/response bytes (port B).
- Accepts bytes over valid/ready and arbitrates round-robin.
- Drives the transmitter's data bus and its load/byte-ready/start strobes, then holds off for one full frame time before accepting the next byte.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_arb2.sv | 27 ++
 rtl/uart_tx_sched.sv | 107 ++++++++++
 tb/tb_uart_tx_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler FSM state type and default frame timing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StStart = 2'd2,
        StWait  = 2'd3
    } tx_state_e;

    localparam int unsigned UART_CLKS_PER_BIT = 16;
    localparam int unsigned UART_FRAME_BITS   = 10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-served register flips priority on each advance.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_b;  // requester 1 was served most recently

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_b ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_b <= 1'b1;
        end else if (advance) begin
            last_b <= gnt[1];
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between two byte requesters, one frame at a time.
// Optional UART_TX_SCHED_STATS_EN adds per-port 16-bit accept counters.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FRAME_BITS   = UART_FRAME_BITS,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [DATA_W-1:0] Data_Bus,
    output logic              Load_XMT_datareg,
    output logic              Byte_ready,
    output logic              T_byte,
    output logic              busy
`ifdef UART_TX_SCHED_STATS_EN
   ,output logic [15:0]       a_count,
    output logic [15:0]       b_count
`endif
);

    localparam int unsigned FrameClks = FRAME_BITS * CLKS_PER_BIT;
    localparam int unsigned CntW      = (FrameClks > 1) ? $clog2(FrameClks) : 1;

    tx_state_e       state;
    logic [CntW-1:0] cnt;
    logic [1:0]      gnt;
    logic            accept;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     ({b_valid, a_valid}),
        .advance (accept),
        .gnt     (gnt)
    );

    // Gated by reset so neither ready can rise while the block is held in reset.
    always_comb begin
        a_ready = reset & (state == StIdle) & gnt[0];
        b_ready = reset & (state == StIdle) & gnt[1];
        accept  = a_ready | b_ready;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= StIdle;
            cnt              <= '0;
            Data_Bus         <= '0;
            Load_XMT_datareg <= 1'b0;
            Byte_ready       <= 1'b0;
            T_byte           <= 1'b0;
            busy             <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        Data_Bus         <= gnt[0] ? a_data : b_data;
                        Load_XMT_datareg <= 1'b1;
                        Byte_ready       <= 1'b1;
                        busy             <= 1'b1;
                        state            <= StLoad;
                    end
                end
                StLoad: begin
                    Load_XMT_datareg <= 1'b0;
                    T_byte           <= 1'b1;
                    state            <= StStart;
                end
                StStart: begin
                    Byte_ready <= 1'b0;
                    T_byte     <= 1'b0;
                    cnt        <= CntW'(FrameClks - 1);
                    state      <= StWait;
                end
                StWait: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef UART_TX_SCHED_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_ready) a_count <= a_count + 16'd1;
            if (b_ready) b_count <= b_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: frame-timeline reference model checked every cycle plus directed pins.
module tb_uart_tx_sched;

    localparam int unsigned CPB        = 2;
    localparam int unsigned FB         = 10;
    localparam int          FRAME_CLKS = CPB * FB;

    logic       clock;
    logic       reset;
    logic       a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready;
    logic [7:0] Data_Bus;
    logic       Load_XMT_datareg, Byte_ready, T_byte, busy;
`ifdef UART_TX_SCHED_STATS_EN
    logic [15:0] a_count, b_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    uart_tx_sched #(
        .CLKS_PER_BIT (CPB),
        .FRAME_BITS   (FB),
        .DATA_W       (8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .a_valid          (a_valid),
        .a_data           (a_data),
        .a_ready          (a_ready),
        .b_valid          (b_valid),
        .b_data           (b_data),
        .b_ready          (b_ready),
        .Data_Bus         (Data_Bus),
        .Load_XMT_datareg (Load_XMT_datareg),
        .Byte_ready       (Byte_ready),
        .T_byte           (T_byte),
        .busy             (busy)
`ifdef UART_TX_SCHED_STATS_EN
       ,.a_count          (a_count),
        .b_count          (b_count)
`endif
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame occupies the transmitter from handshake cycle N up to N+2+FRAME_CLKS.
    int   hs_cyc;
    logic last_b;
    logic [7:0] bus_m;
    int   rel;
    bit   ga, gb;

    initial begin
        hs_cyc = -1000; last_b = 1'b1; bus_m = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                hs_cyc = -1000; last_b = 1'b1; bus_m = '0;
                chk("rst_a_ready", {31'd0, a_ready}, 0);
                chk("rst_b_ready", {31'd0, b_ready}, 0);
                chk("rst_load", {31'd0, Load_XMT_datareg}, 0);
                chk("rst_byte_ready", {31'd0, Byte_ready}, 0);
                chk("rst_t_byte", {31'd0, T_byte}, 0);
                chk("rst_busy", {31'd0, busy}, 0);
                chk("rst_data_bus", {24'd0, Data_Bus}, 0);
            end else begin
                rel = cyc - hs_cyc;
                ga = 0; gb = 0;
                if (rel >= 3 + FRAME_CLKS) begin
                    if (a_valid && b_valid) begin
                        ga = last_b; gb = !last_b;
                    end else begin
                        ga = a_valid; gb = b_valid;
                    end
                end
                chk("a_ready", {31'd0, a_ready}, {31'd0, ga});
                chk("b_ready", {31'd0, b_ready}, {31'd0, gb});
                chk("load", {31'd0, Load_XMT_datareg}, (rel == 1) ? 1 : 0);
                chk("byte_ready", {31'd0, Byte_ready}, (rel == 1 || rel == 2) ? 1 : 0);
                chk("t_byte", {31'd0, T_byte}, (rel == 2) ? 1 : 0);
                chk("busy", {31'd0, busy}, (rel >= 1 && rel <= 2 + FRAME_CLKS) ? 1 : 0);
                chk("data_bus", {24'd0, Data_Bus}, {24'd0, bus_m});
                if (ga || gb) begin
                    hs_cyc = cyc;
                    bus_m  = ga ? a_data : b_data;
                    last_b = gb;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // Presents one byte on a port, waits (bounded) for ready, returns the handshake cycle.
    task automatic send(input bit use_b, input logic [7:0] d, output int n);
        if (use_b) begin b_data = d; b_valid = 1'b1; end
        else begin a_data = d; a_valid = 1'b1; end
        n = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if ((use_b ? b_ready : a_ready) === 1'b1) begin
                n = cyc;
                break;
            end
            tick();
        end
        vectors++;
        if (n < 0) begin
            miscompares++;
            $display("FAIL send_timeout: got no ready required ready for byte %0h", d);
        end
        tick();
        if (use_b) b_valid = 1'b0; else a_valid = 1'b0;
    endtask

    // Waits for whichever port is granted while both may be valid; drops only that valid.
    task automatic take_any(output bit got_b, output int n);
        n = -1; got_b = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (a_ready === 1'b1 || b_ready === 1'b1) begin
                n = cyc; got_b = (b_ready === 1'b1);
                break;
            end
            tick();
        end
        vectors++;
        if (n < 0) begin
            miscompares++;
            $display("FAIL take_timeout: got no ready required a ready");
        end
        tick();
        if (got_b) b_valid = 1'b0; else a_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    int  n1, n2, n3, c0;
    bit  gotb;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; a_valid = 0; b_valid = 0; a_data = '0; b_data = '0;
        #20 reset = 1'b1;
        tick();

        // Single A byte: latency pins and earliest next ready.
        send(0, 8'h41, n1);
        chk("t1_load", {31'd0, Load_XMT_datareg}, 1);
        chk("t1_bus", {24'd0, Data_Bus}, 32'h41);
        tick();
        chk("t1_t_byte", {31'd0, T_byte}, 1);
        send(0, 8'h42, n2);
        chk("t1_gap", n2 - n1, 23);

        // Simultaneous pairs after reset: A first, then alternating.
        pulse_reset();
        a_data = 8'h11; b_data = 8'h22; a_valid = 1; b_valid = 1;
        take_any(gotb, n1);
        chk("t2_first_port", {31'd0, gotb}, 0);
        chk("t2_first_bus", {24'd0, Data_Bus}, 32'h11);
        take_any(gotb, n2);
        chk("t2_second_port", {31'd0, gotb}, 1);
        chk("t2_second_bus", {24'd0, Data_Bus}, 32'h22);
        chk("t2_gap", n2 - n1, 23);
        a_data = 8'h33; b_data = 8'h44; a_valid = 1; b_valid = 1;
        take_any(gotb, n1);
        chk("t2_third_bus", {24'd0, Data_Bus}, 32'h33);
        take_any(gotb, n2);
        chk("t2_fourth_bus", {24'd0, Data_Bus}, 32'h44);

        // B-only stream, back to back.
        send(1, 8'hA0, n1);
        send(1, 8'hA1, n2);
        send(1, 8'hA2, n3);
        chk("t3_gap1", n2 - n1, 23);
        chk("t3_gap2", n3 - n2, 23);
        chk("t3_last_bus", {24'd0, Data_Bus}, 32'hA2);

        // A raised during WAIT is taken in the first idle cycle.
        send(0, 8'h77, n1);
        repeat (5) tick();
        a_data = 8'h78; a_valid = 1'b1;
        #1 chk("t4_ready_in_wait", {31'd0, a_ready}, 0);
        send(0, 8'h78, n2);
        chk("t4_gap", n2 - n1, 23);

        // Asynchronous reset mid-frame.
        send(0, 8'h55, n1);
        repeat (5) tick();
        #2 reset = 1'b0;
        #1;
        chk("t5_load", {31'd0, Load_XMT_datareg}, 0);
        chk("t5_byte_ready", {31'd0, Byte_ready}, 0);
        chk("t5_t_byte", {31'd0, T_byte}, 0);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_bus", {24'd0, Data_Bus}, 0);
        tick(); tick();
        reset = 1'b1;
        c0 = cyc;
        send(0, 8'h66, n1);
        chk("t5_accept_now", n1, c0);
        chk("t5_bus_after", {24'd0, Data_Bus}, 32'h66);

        // Completes 3 A and 2 B since the last reset.
        send(1, 8'hB0, n1);
        send(0, 8'h67, n1);
        send(1, 8'hB1, n1);
        send(0, 8'h68, n1);
        for (int i = 0; i < 40 && busy === 1'b1; i++) tick();
        chk("drain_busy", {31'd0, busy}, 0);
`ifdef UART_TX_SCHED_STATS_EN
        chk("a_count", {16'd0, a_count}, 3);
        chk("b_count", {16'd0, b_count}, 2);
`endif
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
